// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if
//   Groups the upstream (in_*) and downstream (out_*) valid/ready channels of
//   one pipeline stage.
//   Modports:
//     slave  - the pipeline stage: consumes in_*, produces out_*
//     master - the surrounding pipeline: produces in_*, consumes out_*
//   Signals:
//     in_valid/in_ready/in_data/in_ctrl     upstream transfer
//     out_valid/out_ready/out_data/out_ctrl downstream transfer
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Pipeline register stage with valid/ready handshake, hazard stall, flush,
//   occupancy report and a saturating downstream-bubble counter.
//   Optional macro PIPE_STAGE_SKID_EN adds a skid entry behind the head and
//   makes in_ready a registered signal.
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset
//     bus        slave modport of pipe_stage_reg_if (in_* / out_* channels)
//     stall      in   hazard hold, blocks acceptance only
//     flush      in   squash all held entries at the next edge
//     occupancy  out  number of valid entries held (0..1, 0..2 with skid)
//     bubble_cnt out  saturating count of cycles with out_ready & ~out_valid
module pipe_stage_reg #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_stage_reg_if.slave        bus,
    input  logic                   stall,
    input  logic                   flush,
    output logic [1:0]             occupancy,
    output logic [15:0]            bubble_cnt
);

    logic              r_head_valid;
    logic [DATA_W-1:0] r_head_data;
    logic [CTRL_W-1:0] r_head_ctrl;
    logic [15:0]       r_bubble_cnt;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_xfer  = bus.in_valid & bus.in_ready;
    assign w_out_xfer = r_head_valid & bus.out_ready;

    // Empty head always holds zero data and CTRL_NOP, so outputs need no muxing.
    assign bus.out_valid = r_head_valid;
    assign bus.out_data  = r_head_data;
    assign bus.out_ctrl  = r_head_ctrl;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_rdy;
    logic              w_head_valid_nxt;
    logic [DATA_W-1:0] w_head_data_nxt;
    logic [CTRL_W-1:0] w_head_ctrl_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;

    // Registered ready breaks the combinational path from out_ready.
    assign bus.in_ready = r_rdy & ~flush & ~rst;
    assign occupancy    = {1'b0, r_head_valid} + {1'b0, r_skid_valid};

    always_comb begin
        w_head_valid_nxt = r_head_valid;
        w_head_data_nxt  = r_head_data;
        w_head_ctrl_nxt  = r_head_ctrl;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        w_skid_ctrl_nxt  = r_skid_ctrl;
        if (!r_head_valid || w_out_xfer) begin
            // Head is free this edge: skid entry (older) moves up first.
            if (r_skid_valid) begin
                w_head_valid_nxt = 1'b1;
                w_head_data_nxt  = r_skid_data;
                w_head_ctrl_nxt  = r_skid_ctrl;
                w_skid_valid_nxt = w_in_xfer;
                w_skid_data_nxt  = w_in_xfer ? bus.in_data : '0;
                w_skid_ctrl_nxt  = w_in_xfer ? bus.in_ctrl : CTRL_NOP;
            end else if (w_in_xfer) begin
                w_head_valid_nxt = 1'b1;
                w_head_data_nxt  = bus.in_data;
                w_head_ctrl_nxt  = bus.in_ctrl;
            end else begin
                w_head_valid_nxt = 1'b0;
                w_head_data_nxt  = '0;
                w_head_ctrl_nxt  = CTRL_NOP;
            end
        end else if (w_in_xfer && !r_skid_valid) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = bus.in_data;
            w_skid_ctrl_nxt  = bus.in_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
            r_head_ctrl  <= CTRL_NOP;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= CTRL_NOP;
            r_rdy        <= ~stall;
        end else begin
            r_head_valid <= w_head_valid_nxt;
            r_head_data  <= w_head_data_nxt;
            r_head_ctrl  <= w_head_ctrl_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_ctrl  <= w_skid_ctrl_nxt;
            r_rdy        <= ~w_skid_valid_nxt & ~stall;
        end
    end
`else
    assign bus.in_ready = ~rst & ~stall & ~flush & (~r_head_valid | bus.out_ready);
    assign occupancy    = {1'b0, r_head_valid};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
            r_head_ctrl  <= CTRL_NOP;
        end else if (w_in_xfer) begin
            r_head_valid <= 1'b1;
            r_head_data  <= bus.in_data;
            r_head_ctrl  <= bus.in_ctrl;
        end else if (w_out_xfer) begin
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
            r_head_ctrl  <= CTRL_NOP;
        end
    end
`endif

    // Flush deliberately does not touch the bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (bus.out_ready && !r_head_valid && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;

endmodule
